// File: rtl/pipelined_rca_adder.sv
// ---------------------------------------------------------------------------
// pipelined_rca_adder
//
// Pipelined ripple-carry adder for the FIR datapath.
//
// The BIT_WIDTH-bit sum add_1 + add_2 + c_in is split into STAGES equal
// segments of SEG_W = BIT_WIDTH/STAGES bits. Each pipeline stage ripples one
// segment and registers that segment's carry for the next stage. The longest
// combinational path is therefore SEG_W full-adder cells.
//
// A valid/ready handshake with backpressure moves the whole pipe at once.
// While the output holds a result that downstream has not accepted, every
// stage holds.
//
// Parameters:
//   BIT_WIDTH  operand / sum width (default 16)
//   STAGES     number of pipeline stages; must divide BIT_WIDTH (default 4)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands presented
//   in_ready   operands accepted this cycle (combinational, independent of in_valid)
//   add_1      operand A
//   add_2      operand B
//   c_in       carry into bit 0
//   out_valid  sum / c_out (/ ovf) are valid
//   out_ready  downstream accepts the result
//   sum        (add_1 + add_2 + c_in) mod 2^BIT_WIDTH
//   c_out      carry out of the MSB
//   ovf        signed overflow (only when PIPE_RCA_OVF_EN is defined)
//
// Optional feature macro: PIPE_RCA_OVF_EN adds the ovf port and its register.
// ---------------------------------------------------------------------------
module pipelined_rca_adder #(
    parameter int BIT_WIDTH = 16,
    parameter int STAGES    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] add_1,
    input  logic [BIT_WIDTH-1:0] add_2,
    input  logic                 c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
`ifdef PIPE_RCA_OVF_EN
    output logic                 ovf,
`endif
    output logic                 c_out
);

    localparam int SEG_W = BIT_WIDTH / STAGES;

    // Refuse to build a pipe whose segments would not tile the operand.
    if (STAGES < 1 || (BIT_WIDTH % STAGES) != 0) begin : g_badCfg
        $error("pipelined_rca_adder: STAGES must be >= 1 and divide BIT_WIDTH");
    end

    // One segment of plain full-adder cells; the returned MSB is the carry out.
    function automatic logic [SEG_W:0] rippleAdd(input logic [SEG_W-1:0] a,
                                                 input logic [SEG_W-1:0] b,
                                                 input logic             cin);
        logic             c;
        logic [SEG_W-1:0] s;
        c = cin;
        s = '0;
        for (int i = 0; i < SEG_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    // The whole pipe advances together. It holds only when a finished result
    // is waiting on a busy downstream.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE_W = (k + 1) * SEG_W;

        logic              valid_d;
        logic              valid_q;
        logic              carryIn;
        logic              carry_q;
        logic [SEG_W-1:0]  segA;
        logic [SEG_W-1:0]  segB;
        logic [SEG_W:0]    segRes;
        logic [DONE_W-1:0] sumDone_d;
        logic [DONE_W-1:0] sumDone_q;

        // Stage 0 takes its segment straight from the ports. Later stages take
        // it from the operand bits that the previous stage has not consumed
        // yet. The finished low segments travel along with the transaction.
        if (k == 0) begin : g_src
            assign valid_d   = in_valid && advance;
            assign segA      = add_1[SEG_W-1:0];
            assign segB      = add_2[SEG_W-1:0];
            assign carryIn   = c_in;
            assign sumDone_d = segRes[SEG_W-1:0];
        end else begin : g_src
            assign valid_d   = g_stage[k-1].valid_q;
            assign segA      = g_stage[k-1].g_rem.remA_q[SEG_W-1:0];
            assign segB      = g_stage[k-1].g_rem.remB_q[SEG_W-1:0];
            assign carryIn   = g_stage[k-1].carry_q;
            assign sumDone_d = {segRes[SEG_W-1:0], g_stage[k-1].sumDone_q};
        end

        assign segRes = rippleAdd(segA, segB, carryIn);

        // Stage register: the valid bit, the segment carry, and the completed
        // low sum bits. Bubbles move through as valid=0 and are not collapsed.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q   <= 1'b0;
                carry_q   <= 1'b0;
                sumDone_q <= '0;
            end else if (advance) begin
                valid_q   <= valid_d;
                carry_q   <= segRes[SEG_W];
                sumDone_q <= sumDone_d;
            end
        end

        // Every stage except the last carries the operand bits that later
        // stages still need.
        if (k < STAGES - 1) begin : g_rem
            localparam int REM_W = BIT_WIDTH - DONE_W;

            logic [REM_W-1:0] remA_d;
            logic [REM_W-1:0] remB_d;
            logic [REM_W-1:0] remA_q;
            logic [REM_W-1:0] remB_q;

            if (k == 0) begin : g_remSrc
                assign remA_d = add_1[BIT_WIDTH-1:SEG_W];
                assign remB_d = add_2[BIT_WIDTH-1:SEG_W];
            end else begin : g_remSrc
                assign remA_d = g_stage[k-1].g_rem.remA_q[REM_W+SEG_W-1:SEG_W];
                assign remB_d = g_stage[k-1].g_rem.remB_q[REM_W+SEG_W-1:SEG_W];
            end

            // Upper operand bits shift with the transaction they belong to.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    remA_q <= '0;
                    remB_q <= '0;
                end else if (advance) begin
                    remA_q <= remA_d;
                    remB_q <= remB_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sumDone_q;
    assign c_out     = g_stage[STAGES-1].carry_q;

`ifdef PIPE_RCA_OVF_EN
    // The carry into the MSB is recovered as a ^ b ^ sum at that bit. Signed
    // overflow is that carry XOR the carry out.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = (g_stage[STAGES-1].segA[SEG_W-1] ^
                    g_stage[STAGES-1].segB[SEG_W-1] ^
                    g_stage[STAGES-1].segRes[SEG_W-1]) ^
                   g_stage[STAGES-1].segRes[SEG_W];

    // Registered alongside the sum, so it holds under a stall just like sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
